avalon_sdram_width_adapter: RTL and testbench
=============================================

Name: avalon_sdram_width_adapter

Overview:
Avalon-MM 32-bit to 16-bit width adapter sitting directly upstream of avalon_sdram_controller. It accepts 32-bit word accesses from a system master and splits each into two 16-bit halfword accesses on the controller's avs_* port. Read halves returning on readdatavalid are reassembled into 32-bit words. Pipelined reads are supported up to a configurable number of outstanding halfwords.

Parameters:
- SADDR_W, 24, upstream word-address width; downstream address width is SADDR_W+1 (25, matches controller).
- MAX_PEND, 8, maximum outstanding read halfwords in the controller (even, >=2).

Ports:
- clk  input  1  system clock, also the controller clock
- reset  input  1  asynchronous, active-low reset
- s_read  input  1  upstream read request
- s_write  input  1  upstream write request
- s_address  input  SADDR_W  upstream 32-bit word address
- s_byteenable  input  4  upstream byte enables
- s_writedata  input  32  upstream write data
- s_waitrequest  output  1  upstream stall
- s_readdatavalid  output  1  upstream read data valid
- s_readdata  output  32  upstream read data
- m_read  output  1  to controller avs_read
- m_write  output  1  to controller avs_write
- m_address  output  SADDR_W+1  to controller avs_address, halfword address
- m_byteenable  output  2  to controller avs_byteenable
- m_writedata  output  16  to controller avs_writedata
- m_waitrequest  input  1  from controller avs_waitrequest
- m_readdatavalid  input  1  from controller avs_readdatavalid
- m_readdata  input  16  from controller avs_readdata

Behaviour:
- Upstream master holds s_* stable while s_waitrequest=1. The adapter drives m_* combinationally from s_* plus a phase register; no command registering.
- phase register: LO/HI, reset LO. m_address = {s_address, phase==HI}. m_byteenable = s_byteenable[1:0] in LO, [3:2] in HI. m_writedata = s_writedata[15:0] in LO, [31:16] in HI.
- Read, phase LO: m_read=1 only if pend <= MAX_PEND-2. On !m_waitrequest -> HI. Phase HI: m_read=1; on !m_waitrequest -> LO and the upstream read is accepted (s_waitrequest=0 in that cycle).
- Write: a half whose byteenable is 2'b00 is skipped. be[1:0]==0 -> LO issues nothing and moves to HI the same cycle (combinationally, m_address low bit=1). be[3:2]==0 -> accepted when the LO half completes. be==4'b0 -> accepted in one cycle with no m_ access.
- s_waitrequest=1 in every cycle except the cycle in which the final required half is accepted downstream (or the be==0 write cycle).
- s_read and s_write both high is illegal; read takes priority.
- pend counter, reset 0, width clog2(MAX_PEND+1): +1 per accepted m_read and -1 per m_readdatavalid; both in one cycle gives net 0. The gating rule ensures both halves of a read issue back-to-back, so pairs never split across a stall.
- Reassembly: rd_hi flag (reset 0) toggles on each m_readdatavalid. When rd_hi=0, m_readdata is captured into lo_reg. When rd_hi=1, s_readdatavalid=1 and s_readdata={m_readdata, lo_reg}; this path is combinational, so latency is 0 cycles from the second half.
- Writes may be issued while reads are outstanding; the controller preserves order.
- Reset values: s_readdatavalid=0, s_readdata=0 (lo_reg=0), m_read=0, m_write=0. s_waitrequest=1 while reset is asserted. Reset mid-transaction drops pending reads; the master must not expect their data.

Decomposition:
- Package sdram_adapter_pkg: phase_e enum {PH_LO, PH_HI}, and a function deriving the pend width from MAX_PEND.
- One sub-module, sdram_rd_assembler, containing rd_hi, lo_reg and the s_readdata/s_readdatavalid output.
- Top level holds the phase FSM, the pend counter and the command mux.

Test Plan:
- Write addr 0x000010, be=4'hF, data 0xDEADBEEF, m_waitrequest=0 -> m_ writes (0x20, 0xBEEF, be 2'b11) then (0x21, 0xDEAD); s_waitrequest low only in the 2nd cycle.
- Write be=4'hC, data 0x12345678 -> a single m_write to the odd address with data 0x1234, be 2'b11. Write be=4'h0 -> no m_ activity, accepted in 1 cycle.
- Read addr 0x10 after the first write, with sdr model behind the controller -> s_readdatavalid once, s_readdata=0xDEADBEEF.
- Four back-to-back reads with MAX_PEND=4 -> third read stalls in LO until pend<=2; all 4 words return in order.
- m_waitrequest held high for 5 cycles during the HI half -> m_address/data stable, phase stays HI, s_waitrequest stays high throughout.
- Assert reset with 2 halves pending -> pend=0, rd_hi=0, phase=LO, s_readdatavalid=0. A subsequent read returns correct data.

Source files
------------

// File: rtl/sdram_adapter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_adapter_pkg                                                  |
// | Shared types and helpers for the 32-to-16 SDRAM width adapter.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package sdram_adapter_pkg;

  typedef enum logic [0:0] {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

  // Counter must hold the value MAX_PEND itself, not just MAX_PEND-1.
  function automatic int pend_width(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_rd_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_rd_assembler                                                 |
// | Pairs returning 16-bit read halves into 32-bit upstream words.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sdram_rd_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_readdatavalid,
  input  logic [15:0] m_readdata,
  output logic        s_readdatavalid,
  output logic [31:0] s_readdata
);

  logic        rd_hi_q, rd_hi_d;
  logic [15:0] lo_q, lo_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_hi_q <= 1'b0;
      lo_q    <= 16'h0000;
    end else begin
      rd_hi_q <= rd_hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    rd_hi_d = rd_hi_q;
    lo_d    = lo_q;
    if (m_readdatavalid) begin
      rd_hi_d = ~rd_hi_q;
      if (!rd_hi_q) begin
        lo_d = m_readdata;
      end
    end
  end

  // Upper half is forwarded straight through so the word is valid with it.
  always_comb begin
    s_readdatavalid = m_readdatavalid & rd_hi_q;
    s_readdata      = s_readdatavalid ? {m_readdata, lo_q} : 32'h0000_0000;
  end

endmodule

`default_nettype wire

// File: rtl/avalon_sdram_width_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | avalon_sdram_width_adapter                                         |
// | Splits 32-bit Avalon-MM accesses into 16-bit controller accesses.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module avalon_sdram_width_adapter
  import sdram_adapter_pkg::*;
#(
  parameter int SADDR_W  = 24,
  parameter int MAX_PEND = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [SADDR_W-1:0] s_address,
  input  logic [3:0]         s_byteenable,
  input  logic [31:0]        s_writedata,
  output logic               s_waitrequest,
  output logic               s_readdatavalid,
  output logic [31:0]        s_readdata,
  output logic               m_read,
  output logic               m_write,
  output logic [SADDR_W:0]   m_address,
  output logic [1:0]         m_byteenable,
  output logic [15:0]        m_writedata,
  input  logic               m_waitrequest,
  input  logic               m_readdatavalid,
  input  logic [15:0]        m_readdata
);

  localparam int                PEND_W   = pend_width(MAX_PEND);
  localparam logic [PEND_W-1:0] PEND_LIM = PEND_W'(MAX_PEND - 2);

  phase_e            phase_q, phase_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              rd_req, wr_req;
  logic              be_lo_any, be_hi_any;
  logic              half_hi;
  logic              accept;
  logic              m_read_w, m_write_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_LO;
      pend_q  <= '0;
    end else begin
      phase_q <= phase_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (rd_req) begin
      if (phase_q == PH_LO) begin
        if (m_read_w && !m_waitrequest) phase_d = PH_HI;
      end else if (!m_waitrequest) begin
        phase_d = PH_LO;
      end
    end else if (wr_req) begin
      if (phase_q == PH_HI) begin
        if (!m_waitrequest) phase_d = PH_LO;
      end else if (be_lo_any && be_hi_any && !m_waitrequest) begin
        phase_d = PH_HI;
      end
    end
  end

  // A write with an empty low half presents its high half immediately.
  always_comb begin
    rd_req    = reset & s_read;
    wr_req    = reset & s_write & ~s_read;
    be_lo_any = |s_byteenable[1:0];
    be_hi_any = |s_byteenable[3:2];
    half_hi   = (phase_q == PH_HI) || (wr_req && !be_lo_any);
    m_read_w  = rd_req && ((phase_q == PH_HI) || (pend_q <= PEND_LIM));
    m_write_w = wr_req && (half_hi ? be_hi_any : 1'b1);
    accept    = 1'b0;
    if (rd_req) begin
      accept = (phase_q == PH_HI) && !m_waitrequest;
    end else if (wr_req) begin
      if (!be_lo_any && !be_hi_any) begin
        accept = 1'b1;
      end else if (half_hi) begin
        accept = !m_waitrequest;
      end else begin
        accept = !be_hi_any && !m_waitrequest;
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    case ({m_read_w && !m_waitrequest, m_readdatavalid})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  always_comb begin
    s_waitrequest = ~accept;
    m_read        = m_read_w;
    m_write       = m_write_w;
    m_address     = {s_address, half_hi};
    m_byteenable  = half_hi ? s_byteenable[3:2] : s_byteenable[1:0];
    m_writedata   = half_hi ? s_writedata[31:16] : s_writedata[15:0];
  end

  sdram_rd_assembler u_asm (
    .clk             (clk),
    .reset           (reset),
    .m_readdatavalid (m_readdatavalid),
    .m_readdata      (m_readdata),
    .s_readdatavalid (s_readdatavalid),
    .s_readdata      (s_readdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_avalon_sdram_width_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_avalon_sdram_width_adapter                                      |
// | Directed bench with a small halfword SDRAM controller model.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_avalon_sdram_width_adapter;
  import sdram_adapter_pkg::*;

  localparam int SADDR_W  = 24;
  localparam int MAX_PEND = 4;
  localparam int LAT      = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_read, s_write;
  logic [SADDR_W-1:0] s_address;
  logic [3:0]         s_byteenable;
  logic [31:0]        s_writedata;
  logic               s_waitrequest, s_readdatavalid;
  logic [31:0]        s_readdata;
  logic               m_read, m_write;
  logic [SADDR_W:0]   m_address;
  logic [1:0]         m_byteenable;
  logic [15:0]        m_writedata;
  logic               m_waitrequest;
  logic               m_readdatavalid = 1'b0;
  logic [15:0]        m_readdata = 16'h0000;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  avalon_sdram_width_adapter #(.SADDR_W(SADDR_W), .MAX_PEND(MAX_PEND)) dut (
    .clk             (clk),
    .reset           (reset),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_address       (s_address),
    .s_byteenable    (s_byteenable),
    .s_writedata     (s_writedata),
    .s_waitrequest   (s_waitrequest),
    .s_readdatavalid (s_readdatavalid),
    .s_readdata      (s_readdata),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .m_readdatavalid (m_readdatavalid),
    .m_readdata      (m_readdata)
  );

  // Controller model: fixed read latency, records every accepted write.
  typedef struct {
    logic [15:0] d;
    int          due;
  } rsp_t;

  logic [15:0] mem [0:255];
  rsp_t        rq[$];
  logic [42:0] wtrace[$];
  logic [31:0] rdq[$];
  int          cyc = 0;
  int          outst = 0;
  int          max_out = 0;

  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq.delete();
      outst = 0;
      m_readdatavalid <= 1'b0;
      m_readdata      <= 16'h0000;
    end else begin
      cyc++;
      outst = outst + int'(m_read && !m_waitrequest) - int'(m_readdatavalid);
      if (outst > max_out) max_out = outst;
      if (m_write && !m_waitrequest) begin
        if (m_byteenable[0]) mem[m_address[7:0]][7:0]  = m_writedata[7:0];
        if (m_byteenable[1]) mem[m_address[7:0]][15:8] = m_writedata[15:8];
        wtrace.push_back({m_address, m_writedata, m_byteenable});
      end
      if (m_read && !m_waitrequest) rq.push_back('{mem[m_address[7:0]], cyc + LAT});
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        m_readdatavalid <= 1'b1;
        m_readdata      <= rq[0].d;
        void'(rq.pop_front());
      end else begin
        m_readdatavalid <= 1'b0;
        m_readdata      <= 16'h5A5A;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && s_readdatavalid) rdq.push_back(s_readdata);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Presents one upstream command and holds it until accepted.
  task automatic do_cmd(input logic rd, input logic [23:0] a, input logic [3:0] be,
                        input logic [31:0] d, output int ncyc);
    logic w;
    logic done;
    ncyc = 0;
    done = 1'b0;
    @(negedge clk);
    s_read       = rd;
    s_write      = !rd;
    s_address    = a;
    s_byteenable = be;
    s_writedata  = d;
    for (int i = 0; i < 60; i++) begin
      #1 w = s_waitrequest;
      @(posedge clk);
      ncyc++;
      if (!w) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) chk("cmd_accept", done, 1'b1);
  endtask

  task automatic idle();
    @(negedge clk);
    s_read  = 1'b0;
    s_write = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 100 && rdq.size() < n; i++) @(negedge clk);
    if (rdq.size() < n) chk("rd_words", rdq.size(), n);
  endtask

  int n;
  int nr[4];

  initial begin
    reset         = 1'b0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_address     = '0;
    s_byteenable  = 4'h0;
    s_writedata   = 32'h0;
    m_waitrequest = 1'b0;

    // Reset state, with a read request presented to prove gating
    @(negedge clk);
    s_read = 1'b1;
    #1;
    chk("rst_s_wait", s_waitrequest, 1'b1);
    chk("rst_s_rdv", s_readdatavalid, 1'b0);
    chk("rst_s_rdata", s_readdata, 32'h0);
    chk("rst_m_read", m_read, 1'b0);
    chk("rst_m_write", m_write, 1'b0);
    @(negedge clk);
    s_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Full-word write
    wtrace.delete();
    do_cmd(1'b0, 24'h000010, 4'hF, 32'hDEADBEEF, n);
    idle();
    chk("wrF_cycles", n, 2);
    chk("wrF_count", wtrace.size(), 2);
    chk("wrF_half0", wtrace[0], {25'h20, 16'hBEEF, 2'b11});
    chk("wrF_half1", wtrace[1], {25'h21, 16'hDEAD, 2'b11});

    // Upper-half-only write
    wtrace.delete();
    do_cmd(1'b0, 24'h000011, 4'hC, 32'h12345678, n);
    idle();
    chk("wrC_cycles", n, 1);
    chk("wrC_count", wtrace.size(), 1);
    chk("wrC_half", wtrace[0], {25'h23, 16'h1234, 2'b11});

    // Empty byteenable write
    wtrace.delete();
    do_cmd(1'b0, 24'h000012, 4'h0, 32'hFFFFFFFF, n);
    idle();
    chk("wr0_cycles", n, 1);
    chk("wr0_count", wtrace.size(), 0);

    // Single reads
    rdq.delete();
    do_cmd(1'b1, 24'h000010, 4'hF, 32'h0, n);
    idle();
    chk("rd10_cycles", n, 2);
    wait_words(1);
    chk("rd10_data", rdq[0], 32'hDEADBEEF);
    repeat (10) @(negedge clk);
    chk("rd10_once", rdq.size(), 1);
    rdq.delete();
    do_cmd(1'b1, 24'h000011, 4'hF, 32'h0, n);
    idle();
    wait_words(1);
    chk("rd11_data", rdq[0], 32'h12340000);

    // Four pipelined reads against the pend limit
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, 24'h000020 + 24'(i), 4'hF, 32'h11111111 * (i + 1), n);
    end
    idle();
    rdq.delete();
    max_out = 0;
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, 24'h000020 + 24'(i), 4'hF, 32'h0, nr[i]);
    end
    idle();
    wait_words(4);
    chk("pipe_rd1_cycles", nr[0], 2);
    chk("pipe_rd2_cycles", nr[1], 2);
    chk("pipe_rd3_stalled", nr[2] >= 3, 1'b1);
    chk("pipe_max_pend", max_out, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pipe_word%0d", i), rdq[i], 32'h11111111 * (i + 1));
    end

    // Controller stalls the high half for five cycles
    wtrace.delete();
    @(negedge clk);
    s_write      = 1'b1;
    s_address    = 24'h000030;
    s_byteenable = 4'hF;
    s_writedata  = 32'hCAFEF00D;
    #1;
    chk("stall_lo_addr", m_address, 25'h60);
    chk("stall_lo_wait", s_waitrequest, 1'b1);
    @(negedge clk);
    m_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_hi_addr", m_address, 25'h61);
      chk("stall_hi_data", m_writedata, 16'hCAFE);
      chk("stall_hi_write", m_write, 1'b1);
      chk("stall_hi_swait", s_waitrequest, 1'b1);
      chk("stall_hi_phase", dut.phase_q, PH_HI);
      @(negedge clk);
    end
    m_waitrequest = 1'b0;
    #1;
    chk("stall_release", s_waitrequest, 1'b0);
    @(negedge clk);
    s_write = 1'b0;
    chk("stall_count", wtrace.size(), 2);
    rdq.delete();
    do_cmd(1'b1, 24'h000030, 4'hF, 32'h0, n);
    idle();
    wait_words(1);
    chk("stall_rd_data", rdq[0], 32'hCAFEF00D);

    // Reset with two halves outstanding
    repeat (10) @(negedge clk);
    rdq.delete();
    do_cmd(1'b1, 24'h000020, 4'hF, 32'h0, n);
    idle();
    chk("prerst_pend", dut.pend_q, 2);
    reset = 1'b0;
    #1;
    chk("rst2_pend", dut.pend_q, 0);
    chk("rst2_rdhi", dut.u_asm.rd_hi_q, 1'b0);
    chk("rst2_phase", dut.phase_q, PH_LO);
    chk("rst2_rdv", s_readdatavalid, 1'b0);
    chk("rst2_swait", s_waitrequest, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst2_no_stale", rdq.size(), 0);
    do_cmd(1'b1, 24'h000021, 4'hF, 32'h0, n);
    idle();
    wait_words(1);
    chk("rst2_rd_data", rdq[0], 32'h22222222);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
